// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: branch type encodings,
// the counter reset value and the saturating counter step.
package branch_resolve_unit_pkg;

    // Branch type encodings carried on in_btype
    localparam logic [3:0] B_NONE = 4'd0;
    localparam logic [3:0] B_BEQ  = 4'd1;
    localparam logic [3:0] B_BNE  = 4'd2;
    localparam logic [3:0] B_BLEZ = 4'd3;
    localparam logic [3:0] B_BGTZ = 4'd4;
    localparam logic [3:0] B_BLTZ = 4'd5;
    localparam logic [3:0] B_BGEZ = 4'd6;
    localparam logic [3:0] B_BLT  = 4'd7;
    localparam logic [3:0] B_BGE  = 4'd8;
    localparam logic [3:0] B_BLTU = 4'd9;
    localparam logic [3:0] B_BGEU = 4'd10;

    // Counters start weakly not-taken
    localparam logic [1:0] CTR_RESET = 2'b01;

    // Outcome of decoding one branch
    typedef struct packed {
        logic taken;
        logic illegal;
        logic trains;
    } resolve_t;

    // One step of a 2-bit saturating counter toward the observed outcome
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table of 2-bit saturating counters. One read port with a
// bypass from the update port, one saturating update port.
module bht_2bit_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] ctr [DEPTH];
    logic [1:0] upd_next;

    // Next value of the counter being trained this cycle
    always_comb begin
        upd_next = ctr_step(ctr[upd_idx], upd_taken);
    end

    // Read the prediction, forwarding a same-cycle update to the same entry
    always_comb begin
        rd_taken = ctr[rd_idx][1];
        if (upd_en && (upd_idx == rd_idx)) rd_taken = upd_next[1];
    end

    // Counter storage: all entries weakly not-taken on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_RESET;
        end else if (upd_en) begin
            ctr[upd_idx] <= upd_next;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registers a branch, resolves its condition and reports
// taken/mispredict through a one-entry valid/ready output register, and
// trains a table of 2-bit counters that also serves fetch-time predictions.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DW        = 32,
    parameter int PCW       = 32,
    parameter int IDX_W     = 6,
    parameter bit EN_UNSIGN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [PCW-1:0] pred_pc,
    output logic           pred_taken,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [PCW-1:0] in_pc,
    input  logic [DW-1:0]  in_rs,
    input  logic [DW-1:0]  in_rt,
    input  logic [3:0]     in_btype,
    input  logic           in_pred,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [PCW-1:0] out_pc,
    output logic           out_taken,
    output logic           out_mispredict,
    output logic           out_illegal
);

    logic     accept;
    logic     complete;
    logic     out_train;
    resolve_t res;

    logic rs_eq;
    logic rs_neg;
    logic rs_zero;
    logic rs_lt_signed;
    logic rs_lt_unsigned;

    // Only the index bits of the prediction PC select a counter
    logic unused_pred_pc_bits;
    assign unused_pred_pc_bits = ^{pred_pc[PCW-1:IDX_W+2], pred_pc[1:0]};

    assign in_ready = !out_valid || out_ready;
    assign complete = out_valid && out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Operand relations shared by the condition decoder
    always_comb begin
        rs_eq          = (in_rs == in_rt);
        rs_neg         = in_rs[DW-1];
        rs_zero        = (in_rs == '0);
        rs_lt_signed   = ($signed(in_rs) < $signed(in_rt));
        rs_lt_unsigned = (in_rs < in_rt);
    end

    // Condition decoder: taken/illegal per branch type, and whether it trains
    always_comb begin
        res = '0;
        case (in_btype)
            B_NONE: res.taken = 1'b0;
            B_BEQ:  res.taken = rs_eq;
            B_BNE:  res.taken = !rs_eq;
            B_BLEZ: res.taken = rs_neg || rs_zero;
            B_BGTZ: res.taken = !rs_neg && !rs_zero;
            B_BLTZ: res.taken = rs_neg;
            B_BGEZ: res.taken = !rs_neg;
            B_BLT:  res.taken = rs_lt_signed;
            B_BGE:  res.taken = !rs_lt_signed;
            B_BLTU: begin
                if (EN_UNSIGN) res.taken = rs_lt_unsigned;
                else           res.illegal = 1'b1;
            end
            B_BGEU: begin
                if (EN_UNSIGN) res.taken = !rs_lt_unsigned;
                else           res.illegal = 1'b1;
            end
            default: res.illegal = 1'b1;
        endcase
        res.trains = !res.illegal && (in_btype != B_NONE);
    end

    // Output register: flush beats a new accept; completion empties the slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            out_train      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_pc         <= in_pc;
            out_taken      <= res.taken;
            out_mispredict <= (res.taken != in_pred);
            out_illegal    <= res.illegal;
            out_train      <= res.trains;
        end else if (complete) begin
            out_valid <= 1'b0;
        end
    end

    // Counter table, trained when a legal non-none result completes
    bht_2bit_table #(
        .IDX_W(IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pred_pc[IDX_W+1:2]),
        .rd_taken (pred_taken),
        .upd_en   (complete && out_train),
        .upd_idx  (out_pc[IDX_W+1:2]),
        .upd_taken(out_taken)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: decode table, directed
// multi-cycle sequences and a randomized stream against a reference model.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [3:0]  in_btype;
    logic        in_pred;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_taken;
    logic        out_mispredict;
    logic        out_illegal;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          mctr [64];
    bit          m_valid;
    logic [31:0] m_pc;
    bit          m_taken;
    bit          m_misp;
    bit          m_illegal;
    bit          m_train;

    typedef struct {
        logic [3:0]  bt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        exp_taken;
        logic        exp_illegal;
    } vec_t;

    vec_t tbl[$];

    branch_resolve_unit #(
        .DW(32), .PCW(32), .IDX_W(6), .EN_UNSIGN(1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_btype      (in_btype),
        .in_pred       (in_pred),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_taken     (out_taken),
        .out_mispredict(out_mispredict),
        .out_illegal   (out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) & 32'h3F);
    endfunction

    function automatic int sat_step(int c, bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    // Returns {illegal, taken} straight from the branch definitions
    function automatic logic [1:0] ref_eval(logic [3:0] bt, logic [31:0] rs, logic [31:0] rt);
        int srs;
        int srt;
        longint urs;
        longint urt;
        srs = rs;
        srt = rt;
        urs = longint'({32'd0, rs});
        urt = longint'({32'd0, rt});
        case (bt)
            4'd0:  return 2'b00;
            4'd1:  return {1'b0, rs == rt};
            4'd2:  return {1'b0, rs != rt};
            4'd3:  return {1'b0, srs <= 0};
            4'd4:  return {1'b0, srs > 0};
            4'd5:  return {1'b0, srs < 0};
            4'd6:  return {1'b0, srs >= 0};
            4'd7:  return {1'b0, srs < srt};
            4'd8:  return {1'b0, srs >= srt};
            4'd9:  return {1'b0, urs < urt};
            4'd10: return {1'b0, urs >= urt};
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mctr[i] = 1;
        m_valid = 0;
        m_pc = '0;
        m_taken = 0;
        m_misp = 0;
        m_illegal = 0;
        m_train = 0;
    endtask

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pred(logic [31:0] pc, logic exp);
        pred_pc = pc;
        #1;
        check_output("pred_taken", {31'd0, pred_taken}, {31'd0, exp});
    endtask

    // Compare everything against the model at the falling edge, then advance
    // the model across the next rising edge. Called shortly after a rising edge.
    task automatic tick();
        int pidx;
        int nxt;
        bit comp;
        bit acc;
        logic [1:0] r;
        @(negedge clk);
        check_output("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check_output("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        if (m_valid) begin
            check_output("out_pc", out_pc, m_pc);
            check_output("out_taken", {31'd0, out_taken}, {31'd0, m_taken});
            check_output("out_mispredict", {31'd0, out_mispredict}, {31'd0, m_misp});
            check_output("out_illegal", {31'd0, out_illegal}, {31'd0, m_illegal});
        end
        pidx = idx_of(pred_pc);
        comp = m_valid && out_ready;
        if (comp && m_train && idx_of(m_pc) == pidx) nxt = sat_step(mctr[pidx], m_taken);
        else nxt = mctr[pidx];
        check_output("model_pred", {31'd0, pred_taken}, {31'd0, nxt >= 2});
        @(posedge clk);
        acc = in_valid && (!m_valid || out_ready) && !flush;
        if (comp && m_train) mctr[idx_of(m_pc)] = sat_step(mctr[idx_of(m_pc)], m_taken);
        if (flush) begin
            m_valid = 0;
        end else if (acc) begin
            r = ref_eval(in_btype, in_rs, in_rt);
            m_valid = 1;
            m_pc = in_pc;
            m_taken = r[0];
            m_illegal = r[1];
            m_misp = (r[0] != in_pred);
            m_train = !r[1] && (in_btype != 4'd0);
        end else if (comp) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic apply_stimulus(logic [31:0] pc, logic [3:0] bt, logic [31:0] rs,
                                  logic [31:0] rt, logic pred, logic rdy);
        in_valid = 1'b1;
        in_pc = pc;
        in_btype = bt;
        in_rs = rs;
        in_rt = rt;
        in_pred = pred;
        out_ready = rdy;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(logic [3:0] bt, logic [31:0] rs, logic [31:0] rt,
                                logic t, logic ill);
        vec_t v;
        v.bt = bt;
        v.rs = rs;
        v.rt = rt;
        v.exp_taken = t;
        v.exp_illegal = ill;
        return v;
    endfunction

    logic [31:0] corners [6];

    function automatic logic [31:0] pick_operand();
        int k;
        k = $urandom_range(0, 6);
        if (k == 6) return $urandom;
        return corners[k];
    endfunction

    initial begin
        logic [31:0] pc_pool [4];
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h5;
        pc_pool[0] = 32'h3000;
        pc_pool[1] = 32'h3004;
        pc_pool[2] = 32'h3100;
        pc_pool[3] = 32'h3008;

        tbl.push_back(mk(4'd1, 32'd5, 32'd5, 1'b1, 1'b0));
        tbl.push_back(mk(4'd1, 32'd5, 32'd6, 1'b0, 1'b0));
        tbl.push_back(mk(4'd2, 32'd5, 32'd6, 1'b1, 1'b0));
        tbl.push_back(mk(4'd2, 32'd7, 32'd7, 1'b0, 1'b0));
        tbl.push_back(mk(4'd3, 32'h0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk(4'd3, 32'h1, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd3, 32'h8000_0000, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk(4'd4, 32'h0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd4, 32'h1, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk(4'd4, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd5, 32'h8000_0000, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk(4'd5, 32'h0, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd6, 32'h0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk(4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd7, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0));
        tbl.push_back(mk(4'd7, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0));
        tbl.push_back(mk(4'd9, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0));
        tbl.push_back(mk(4'd9, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0));
        tbl.push_back(mk(4'd10, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0));
        tbl.push_back(mk(4'd10, 32'h3, 32'h3, 1'b1, 1'b0));
        tbl.push_back(mk(4'd0, 32'h5, 32'h5, 1'b0, 1'b0));
        tbl.push_back(mk(4'hB, 32'h5, 32'h5, 1'b0, 1'b1));
        tbl.push_back(mk(4'hF, 32'h0, 32'h0, 1'b0, 1'b1));

        reset = 1'b0;
        pred_pc = 32'h3000;
        in_valid = 1'b0;
        in_pc = '0;
        in_rs = '0;
        in_rt = '0;
        in_btype = '0;
        in_pred = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_out_taken", {31'd0, out_taken}, 32'd0);
        check_output("rst_out_mispredict", {31'd0, out_mispredict}, 32'd0);
        check_output("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        check_output("rst_out_pc", out_pc, 32'd0);
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // beq taken, predicted not-taken: one-cycle latency, bypass, training
        pred_pc = 32'h3000;
        apply_stimulus(32'h3000, 4'd1, 32'd5, 32'd5, 1'b0, 1'b1);
        check_output("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check_output("t1_out_taken", {31'd0, out_taken}, 32'd1);
        check_output("t1_out_mispredict", {31'd0, out_mispredict}, 32'd1);
        check_output("t1_bypass_pred", {31'd0, pred_taken}, 32'd1);
        tick();
        check_output("t1_drained", {31'd0, out_valid}, 32'd0);
        check_output("t1_trained_pred", {31'd0, pred_taken}, 32'd1);

        // Decode table
        foreach (tbl[i]) begin
            logic p;
            p = logic'(i % 2);
            apply_stimulus(32'h8000 + ((i + 32) << 2), tbl[i].bt, tbl[i].rs, tbl[i].rt, p, 1'b1);
            check_output("tbl_taken", {31'd0, out_taken}, {31'd0, tbl[i].exp_taken});
            check_output("tbl_illegal", {31'd0, out_illegal}, {31'd0, tbl[i].exp_illegal});
            check_output("tbl_mispredict", {31'd0, out_mispredict}, {31'd0, tbl[i].exp_taken ^ p});
            tick();
        end
        check_pred(32'h8000 + ((22 + 32) << 2), 1'b0);
        tick();
        check_pred(32'h8000 + ((0 + 32) << 2), 1'b1);
        tick();

        // Saturation up to 11 and down to 00
        apply_stimulus(32'h4004, 4'd1, 32'd1, 32'd1, 1'b0, 1'b1); tick(); check_pred(32'h4004, 1'b1);
        apply_stimulus(32'h4004, 4'd1, 32'd1, 32'd1, 1'b0, 1'b1); tick(); check_pred(32'h4004, 1'b1);
        apply_stimulus(32'h4004, 4'd1, 32'd1, 32'd1, 1'b0, 1'b1); tick(); check_pred(32'h4004, 1'b1);
        apply_stimulus(32'h4004, 4'd2, 32'd1, 32'd1, 1'b1, 1'b1); tick(); check_pred(32'h4004, 1'b1);
        apply_stimulus(32'h4004, 4'd2, 32'd1, 32'd1, 1'b1, 1'b1); tick(); check_pred(32'h4004, 1'b0);
        apply_stimulus(32'h4004, 4'd2, 32'd1, 32'd1, 1'b1, 1'b1); tick(); check_pred(32'h4004, 1'b0);
        apply_stimulus(32'h4004, 4'd2, 32'd1, 32'd1, 1'b1, 1'b1); tick(); check_pred(32'h4004, 1'b0);
        apply_stimulus(32'h4004, 4'd1, 32'd1, 32'd1, 1'b0, 1'b1); tick(); check_pred(32'h4004, 1'b0);
        apply_stimulus(32'h4004, 4'd1, 32'd1, 32'd1, 1'b0, 1'b1); tick(); check_pred(32'h4004, 1'b1);

        // Backpressure with the next branch waiting
        apply_stimulus(32'h5008, 4'd1, 32'd1, 32'd1, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_pc = 32'h500C;
        in_btype = 4'd2;
        in_rs = 32'd2;
        in_rt = 32'd2;
        in_pred = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_output("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_output("bp_out_pc", out_pc, 32'h5008);
            check_output("bp_out_taken", {31'd0, out_taken}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_output("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check_output("bp_second_pc", out_pc, 32'h500C);
        check_output("bp_second_misp", {31'd0, out_mispredict}, 32'd1);
        tick();
        check_output("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush beats a same-cycle accept
        in_valid = 1'b1;
        in_pc = 32'h6010;
        in_btype = 4'd1;
        in_rs = 32'd9;
        in_rt = 32'd9;
        in_pred = 1'b0;
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_output("fl_accept_dropped", {31'd0, out_valid}, 32'd0);
        check_pred(32'h6010, 1'b0);
        tick();
        // Flush of an in-flight branch: no training
        apply_stimulus(32'h6010, 4'd1, 32'd9, 32'd9, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("fl_inflight_dropped", {31'd0, out_valid}, 32'd0);
        check_pred(32'h6010, 1'b0);
        tick();
        // Completion together with flush still trains
        apply_stimulus(32'h6010, 4'd1, 32'd9, 32'd9, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("fl_complete_valid", {31'd0, out_valid}, 32'd0);
        check_pred(32'h6010, 1'b1);
        tick();

        // Write bypass seen through an aliasing prediction PC
        apply_stimulus(32'h7014, 4'd1, 32'd3, 32'd3, 1'b0, 1'b0);
        check_pred(32'h7114, 1'b0);
        out_ready = 1'b1;
        #1;
        check_output("bypass_alias", {31'd0, pred_taken}, 32'd1);
        tick();
        check_output("alias_trained", {31'd0, pred_taken}, 32'd1);

        // Asynchronous reset in the middle of a held transfer
        pred_pc = 32'h3000;
        apply_stimulus(32'h3000, 4'd1, 32'd1, 32'd1, 1'b0, 1'b0);
        check_output("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        check_output("mid_pre_pred", {31'd0, pred_taken}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_output("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("mid_out_taken", {31'd0, out_taken}, 32'd0);
        check_output("mid_out_pc", out_pc, 32'd0);
        check_output("mid_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("mid_pred_taken", {31'd0, pred_taken}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized stream against the reference model
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc = pc_pool[$urandom_range(0, 3)];
            in_btype = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 10));
            in_rs = pick_operand();
            in_rt = ($urandom_range(0, 3) == 0) ? in_rs : pick_operand();
            in_pred = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 9) == 0);
            pred_pc = pc_pool[$urandom_range(0, 3)];
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
